mux_scan_nx1: RTL and testbench

Parametrised, registered N:1 channel selector with a valid/ready output stage, the sequential successor of the combinational 8:1 mux. It picks one W-bit lane out of a packed N-lane input bus, either by an external select (manual mode) or by an internal scan pointer that steps through all channels (scan mode). Each channel is held for a programmable number of beats. It sits between parallel per-channel sources and a single serial consumer, such as a TDM link or a logger.

---
 rtl/mux_scan_nx1.sv | 97 +++++++++
 tb/tb_mux_scan_nx1.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel selector with manual/scan channel choice and a
// single-slot valid/ready output stage.
module mux_scan_nx1 #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sel_err
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   NUM_CH  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
  localparam logic [DW-1:0] LAST_DW = DW'(DWELL - 1);

  logic [SW-1:0] scan_ptr_r;
  logic [DW-1:0] dwell_r;

  logic          slot_free_s;
  logic          sel_ok_s;
  logic [SW-1:0] ch_s;
  logic          ch_ok_s;
  logic          capture_s;
  logic          last_s;
  logic          sel_err_s;
  logic [W-1:0]  lane_s;

  // Channel choice, legality and capture qualification
  always_comb begin
    slot_free_s = !out_valid || out_ready;
    sel_ok_s    = ({1'b0, sel} < NUM_CH);
    ch_s        = mode ? scan_ptr_r : sel;
    ch_ok_s     = mode ? 1'b1 : sel_ok_s;
    capture_s   = en && slot_free_s && ch_ok_s;
    last_s      = mode && (scan_ptr_r == LAST_CH) && (dwell_r == LAST_DW);
    sel_err_s   = !mode && en && !sel_ok_s;
  end

  // One-hot AND-OR lane mux; an out-of-range index yields zero
  always_comb begin
    lane_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      lane_s = lane_s | ({W{ch_s == SW'(k)}} & in_data[k*W +: W]);
    end
  end

  // Output slot and scan state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= {W{1'b0}};
      out_ch     <= {SW{1'b0}};
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      sel_err    <= 1'b0;
      scan_ptr_r <= {SW{1'b0}};
      dwell_r    <= {DW{1'b0}};
    end else begin
      sel_err <= sel_err_s;
      if (capture_s) begin
        out_data  <= lane_s;
        out_ch    <= ch_s;
        out_valid <= 1'b1;
        out_last  <= last_s;
        if (mode) begin
          if (dwell_r == LAST_DW) begin
            dwell_r    <= {DW{1'b0}};
            // Explicit wrap so non-power-of-two N never visits unused codes
            scan_ptr_r <= (scan_ptr_r == LAST_CH) ? {SW{1'b0}} : scan_ptr_r + SW'(1);
          end else begin
            dwell_r    <= dwell_r + DW'(1);
            scan_ptr_r <= scan_ptr_r;
          end
        end else begin
          dwell_r    <= dwell_r;
          scan_ptr_r <= scan_ptr_r;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench: three instances cover manual sweep (N=8),
// scan with dwell (N=5, DWELL=2) and backpressure/illegal/mode/reset (N=5).
module tb_mux_scan_nx1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance a: N=8, W=1, DWELL=1
  logic [7:0] a_in_data;
  logic [2:0] a_sel, a_ch;
  logic       a_mode, a_en, a_ready, a_data, a_valid, a_last, a_err;
  // Instance b: N=5, W=4, DWELL=2
  logic [19:0] b_in_data;
  logic [2:0]  b_sel, b_ch;
  logic [3:0]  b_data;
  logic        b_mode, b_en, b_ready, b_valid, b_last, b_err;
  // Instance c: N=5, W=4, DWELL=1
  logic [19:0] c_in_data;
  logic [2:0]  c_sel, c_ch;
  logic [3:0]  c_data;
  logic        c_mode, c_en, c_ready, c_valid, c_last, c_err;

  mux_scan_nx1 #(.N(8), .W(1), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .mode(a_mode), .en(a_en),
    .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_ready(a_ready),
    .out_last(a_last), .sel_err(a_err));

  mux_scan_nx1 #(.N(5), .W(4), .DWELL(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .mode(b_mode), .en(b_en),
    .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .sel_err(b_err));

  mux_scan_nx1 #(.N(5), .W(4), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel), .mode(c_mode), .en(c_en),
    .out_data(c_data), .out_ch(c_ch), .out_valid(c_valid), .out_ready(c_ready),
    .out_last(c_last), .sel_err(c_err));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_c(input string tag, input logic [2:0] ch, input logic [3:0] data,
                         input logic valid, input logic last);
    check_val({tag, "_ch"}, 32'(c_ch), 32'(ch));
    check_val({tag, "_data"}, 32'(c_data), 32'(data));
    check_val({tag, "_valid"}, 32'(c_valid), 32'(valid));
    check_val({tag, "_last"}, 32'(c_last), 32'(last));
  endtask

  logic [7:0] sweep_exp;
  logic [2:0] dw_ch [12];
  logic       dw_last [12];

  initial begin
    sweep_exp = 8'b1010_0101;
    dw_ch   = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0};
    dw_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    a_in_data = 8'b1010_0101; a_sel = 3'd3; a_mode = 1'b0; a_en = 1'b1; a_ready = 1'b1;
    b_in_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}; b_sel = 3'd0; b_mode = 1'b1; b_en = 1'b1; b_ready = 1'b1;
    c_in_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}; c_sel = 3'd0; c_mode = 1'b1; c_en = 1'b1; c_ready = 1'b1;
    rst = 1'b1;

    // Reset held for two cycles with en=1
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_valid", 32'(a_valid), 32'd0);
      check_val("rst_data", 32'(a_data), 32'd0);
      check_val("rst_ch", 32'(a_ch), 32'd0);
      check_val("rst_last", 32'(a_last), 32'd0);
      check_val("rst_err", 32'(a_err), 32'd0);
      check_val("rst_c_valid", 32'(c_valid), 32'd0);
    end
    rst = 1'b0; a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("idle_valid", 32'(a_valid), 32'd0);
    end

    // Manual sweep, one select per cycle
    a_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      tick();
      check_val("sweep_data", 32'(a_data), 32'(sweep_exp[s]));
      check_val("sweep_ch", 32'(a_ch), 32'(s));
      check_val("sweep_valid", 32'(a_valid), 32'd1);
      check_val("sweep_last", 32'(a_last), 32'd0);
    end
    a_en = 1'b0;

    // Scan with dwell 2 over 5 channels
    b_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("dwell_ch", 32'(b_ch), 32'(dw_ch[i]));
      check_val("dwell_data", 32'(b_data), 32'(dw_ch[i]) + 32'd1);
      check_val("dwell_last", 32'(b_last), 32'(dw_last[i]));
    end
    b_en = 1'b0;

    // Backpressure on channel 2, input changed during the stall
    c_en = 1'b1;
    tick(); check_c("bp0", 3'd0, 4'd1, 1'b1, 1'b0);
    tick(); check_c("bp1", 3'd1, 4'd2, 1'b1, 1'b0);
    tick(); check_c("bp2", 3'd2, 4'd3, 1'b1, 1'b0);
    c_ready = 1'b0;
    c_in_data = {5{4'd9}};
    for (int i = 0; i < 3; i++) begin
      tick(); check_c("stall", 3'd2, 4'd3, 1'b1, 1'b0);
    end
    c_in_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    c_ready = 1'b1;
    tick(); check_c("rel3", 3'd3, 4'd4, 1'b1, 1'b0);
    tick(); check_c("rel4", 3'd4, 4'd5, 1'b1, 1'b1);
    tick(); check_c("wrap0", 3'd0, 4'd1, 1'b1, 1'b0);

    // Illegal manual select drains the slot and flags for one cycle
    c_mode = 1'b0; c_sel = 3'd6;
    tick();
    check_val("ill_err", 32'(c_err), 32'd1);
    check_val("ill_valid", 32'(c_valid), 32'd0);
    c_sel = 3'd3;
    tick();
    check_val("ill_clr", 32'(c_err), 32'd0);
    check_c("ill_ok", 3'd3, 4'd4, 1'b1, 1'b0);

    // Mode switch: scanning resumes from the frozen pointer
    c_mode = 1'b1;
    tick(); check_c("ms1", 3'd1, 4'd2, 1'b1, 1'b0);
    tick(); check_c("ms2", 3'd2, 4'd3, 1'b1, 1'b0);
    c_mode = 1'b0; c_sel = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick(); check_c("man4", 3'd4, 4'd5, 1'b1, 1'b0);
    end
    c_mode = 1'b1;
    tick(); check_c("resume", 3'd3, 4'd4, 1'b1, 1'b0);

    // Reset while a beat is stalled
    c_ready = 1'b0;
    tick(); check_c("hold", 3'd3, 4'd4, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); check_c("midrst", 3'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; c_ready = 1'b1;
    tick(); check_c("post", 3'd0, 4'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
